// File: rtl/vx_rr_stream_arb.sv
// Round-robin stream arbiter: shares one valid/ready output channel among
// NUM_INPUTS requesters, steering the winner's payload through a one-hot
// AND-OR select and exporting the grant as sel_out for side-band muxes.
module vx_rr_stream_arb #(
  parameter int NUM_INPUTS = 4,
  parameter int DATAW      = 32,
  parameter int OUT_BUF    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS-1:0]       valid_in,
  input  logic [NUM_INPUTS*DATAW-1:0] data_in,
  output logic [NUM_INPUTS-1:0]       ready_in,
  output logic                        valid_out,
  output logic [DATAW-1:0]            data_out,
  output logic [NUM_INPUTS-1:0]       sel_out,
  input  logic                        ready_out
);

  localparam int PW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic                  active_r;
  logic [NUM_INPUTS-1:0] rr_grant;
  logic [NUM_INPUTS-1:0] grant;
  logic [DATAW-1:0]      mux_data;
  logic                  xfer;

  assign xfer = |(valid_in & ready_in);

  // Handshakes stay closed during reset and for the first cycle after it.
  always_ff @(posedge clk) begin
    if (reset) active_r <= 1'b0;
    else       active_r <= 1'b1;
  end

  generate
    if (NUM_INPUTS == 1) begin : g_single
      assign rr_grant = valid_in;
    end else begin : g_rr
      logic [PW-1:0] ptr;
      logic [PW-1:0] ptr_next;

      // First valid requester found scanning ptr, ptr+1, ... wraps around.
      function automatic logic [NUM_INPUTS-1:0] rr_pick(
        input logic [NUM_INPUTS-1:0] req,
        input logic [PW-1:0]         p
      );
        logic [NUM_INPUTS-1:0] onehot;
        rr_pick = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
          onehot    = '0;
          onehot[0] = 1'b1;
          onehot    = onehot << ((int'(p) + k) % NUM_INPUTS);
          if (|(req & onehot)) rr_pick = onehot;
        end
      endfunction

      assign rr_grant = rr_pick(valid_in, ptr);

      // Pointer moves to the slot just after the accepted requester.
      always_comb begin
        ptr_next = '0;
        for (int j = 0; j < NUM_INPUTS; j++) begin
          if (grant[j]) ptr_next = PW'((j + 1) % NUM_INPUTS);
        end
      end

      // Priority pointer only advances on an actual upstream transfer.
      always_ff @(posedge clk) begin
        if (reset)     ptr <= '0;
        else if (xfer) ptr <= ptr_next;
      end
    end
  endgenerate

  // One-hot AND-OR payload select; a zero grant yields zero.
  always_comb begin
    mux_data = '0;
    for (int j = 0; j < NUM_INPUTS; j++) begin
      mux_data = mux_data | (data_in[j*DATAW +: DATAW] & {DATAW{grant[j]}});
    end
  end

  generate
    if (OUT_BUF == 0) begin : g_comb
      logic                  lock_r;
      logic [NUM_INPUTS-1:0] lock_grant_r;

      assign grant     = lock_r ? lock_grant_r : rr_grant;
      assign valid_out = active_r & (|valid_in);
      assign ready_in  = grant & {NUM_INPUTS{ready_out & active_r}};
      assign data_out  = mux_data;
      assign sel_out   = grant & {NUM_INPUTS{valid_out}};

      // Freeze the grant while the output beat is stalled so it stays stable.
      always_ff @(posedge clk) begin
        if (reset) begin
          lock_r       <= 1'b0;
          lock_grant_r <= '0;
        end else if (valid_out && !ready_out) begin
          lock_r       <= 1'b1;
          lock_grant_r <= grant;
        end else if (valid_out && ready_out) begin
          lock_r       <= 1'b0;
        end
      end

      // A locked requester must keep its request up until it is accepted.
      assert property (@(posedge clk) disable iff (reset)
                       lock_r |-> |(valid_in & lock_grant_r))
        else $error("locked requester dropped valid_in before acceptance");
    end else begin : g_buf
      logic                  vld_r;
      logic [DATAW-1:0]      data_r;
      logic [NUM_INPUTS-1:0] sel_r;
      logic                  can_accept;

      assign grant      = rr_grant;
      assign can_accept = active_r & (~vld_r | ready_out);
      assign ready_in   = grant & {NUM_INPUTS{can_accept}};
      assign valid_out  = vld_r;
      assign data_out   = data_r;
      assign sel_out    = sel_r;

      // One-entry output stage; refill takes priority over drain.
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_r  <= 1'b0;
          data_r <= '0;
          sel_r  <= '0;
        end else if (xfer) begin
          vld_r  <= 1'b1;
          data_r <= mux_data;
          sel_r  <= grant;
        end else if (ready_out) begin
          vld_r  <= 1'b0;
          sel_r  <= '0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_vx_rr_stream_arb.sv
// Bench for vx_rr_stream_arb: one combinational (u0) and one buffered (u1)
// instance, 4 inputs x 8 bits, checked by tables, directed sequences and a
// randomized run against a behavioural model.
module tb_vx_rr_stream_arb;

  logic       clk;
  logic       rst0, rst1;
  logic [3:0] v0, v1;
  logic [7:0] d0 [4];
  logic [7:0] d1 [4];
  logic       ro0, ro1;
  logic [3:0] rdy0, rdy1, so0, so1;
  logic       vo0, vo1;
  logic [7:0] do0, do1;
  logic [31:0] din0, din1;

  int checks = 0;
  int errors = 0;

  assign din0 = {d0[3], d0[2], d0[1], d0[0]};
  assign din1 = {d1[3], d1[2], d1[1], d1[0]};

  vx_rr_stream_arb #(.NUM_INPUTS(4), .DATAW(8), .OUT_BUF(0)) u0 (
    .clk(clk), .reset(rst0), .valid_in(v0), .data_in(din0), .ready_in(rdy0),
    .valid_out(vo0), .data_out(do0), .sel_out(so0), .ready_out(ro0));

  vx_rr_stream_arb #(.NUM_INPUTS(4), .DATAW(8), .OUT_BUF(1)) u1 (
    .clk(clk), .reset(rst1), .valid_in(v1), .data_in(din1), .ready_in(rdy1),
    .valid_out(vo1), .data_out(do1), .sel_out(so1), .ready_out(ro1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] valid;
    logic [3:0] rdy;
    logic       vo;
    logic [7:0] dat;
    logic [3:0] sel;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] oh(input int w);
    return (w >= 0) ? 4'(1 << w) : 4'b0000;
  endfunction

  initial begin
    int p0, p1, lk0, w0, w1, os1;
    logic ov1, can1;
    logic [7:0] od1;

    tbl[0] = '{4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000};
    tbl[1] = '{4'b1111, 4'b0001, 1'b1, 8'h10, 4'b0001};
    tbl[2] = '{4'b1111, 4'b0010, 1'b1, 8'h11, 4'b0010};
    tbl[3] = '{4'b0001, 4'b0001, 1'b1, 8'h10, 4'b0001};
    tbl[4] = '{4'b1001, 4'b1000, 1'b1, 8'h13, 4'b1000};
    tbl[5] = '{4'b1010, 4'b0010, 1'b1, 8'h11, 4'b0010};
    tbl[6] = '{4'b0011, 4'b0001, 1'b1, 8'h10, 4'b0001};
    tbl[7] = '{4'b0100, 4'b0100, 1'b1, 8'h12, 4'b0100};
    tbl[8] = '{4'b0110, 4'b0010, 1'b1, 8'h11, 4'b0010};

    // Reset behaviour and rotation on the buffered instance
    rst0 = 1'b1; rst1 = 1'b1;
    v0 = 4'b0000; v1 = 4'b1111; ro0 = 1'b1; ro1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d0[i] = 8'h10 + 8'(i);
      d1[i] = 8'hA0 + 8'(i);
    end
    for (int c = 0; c < 2; c++) begin
      step(); #1;
      chk("rst_valid_out", 32'(vo1), 0);
      chk("rst_ready_in", 32'(rdy1), 0);
      chk("rst_sel_out", 32'(so1), 0);
      chk("rst_valid_out_comb", 32'(vo0), 0);
    end
    rst0 = 1'b0; rst1 = 1'b0; #1;
    chk("post_rst_ready_in", 32'(rdy1), 0);
    chk("post_rst_valid_out", 32'(vo1), 0);
    chk("post_rst_sel_out", 32'(so1), 0);
    step(); #1;
    chk("first_grant", 32'(rdy1), 32'b0001);
    chk("first_valid_out", 32'(vo1), 0);
    step(); #1;
    for (int k = 0; k < 5; k++) begin
      chk("rot_valid", 32'(vo1), 1);
      chk("rot_data", 32'(do1), 32'(8'hA0 + 8'(k % 4)));
      chk("rot_sel", 32'(so1), 32'(oh(k % 4)));
      step(); #1;
    end

    // Table-driven single-cycle vectors on the combinational instance
    for (int i = 0; i < 9; i++) begin
      v0 = tbl[i].valid; #1;
      chk("tbl_ready_in", 32'(rdy0), 32'(tbl[i].rdy));
      chk("tbl_valid_out", 32'(vo0), 32'(tbl[i].vo));
      chk("tbl_data_out", 32'(do0), 32'(tbl[i].dat));
      chk("tbl_sel_out", 32'(so0), 32'(tbl[i].sel));
      step();
    end
    v0 = 4'b0000;

    // Backpressure lock: input 2 stalled, input 0 arrives later
    rst0 = 1'b1; step(); step(); rst0 = 1'b0; step();
    d0[0] = 8'h40; d0[2] = 8'h42; ro0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      v0 = (c == 0) ? 4'b0100 : 4'b0101; #1;
      chk("lock_data", 32'(do0), 32'h42);
      chk("lock_sel", 32'(so0), 32'b0100);
      chk("lock_ready_in", 32'(rdy0), 0);
      step();
    end
    ro0 = 1'b1; #1;
    chk("lock_release_data", 32'(do0), 32'h42);
    chk("lock_release_ready", 32'(rdy0), 32'b0100);
    step();
    v0 = 4'b0001; #1;
    chk("after_lock_data", 32'(do0), 32'h40);
    chk("after_lock_sel", 32'(so0), 32'b0001);
    step();

    // Pointer hold while stalled, then pointer lands on 2
    v0 = 4'b0010; d0[1] = 8'h11; ro0 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("hold_ready_in", 32'(rdy0), 0);
      chk("hold_sel", 32'(so0), 32'b0010);
      step();
    end
    ro0 = 1'b1; #1;
    chk("hold_accept", 32'(rdy0), 32'b0010);
    step();
    v0 = 4'b0101; #1;
    chk("ptr_after_hold", 32'(rdy0), 32'b0100);
    chk("ptr_after_hold_data", 32'(do0), 32'h42);
    step();
    v0 = 4'b0000;

    // Drain and refill: input 3 streams 10 beats back to back
    rst1 = 1'b1; v1 = 4'b0000; step(); step(); rst1 = 1'b0; step();
    ro1 = 1'b1; v1 = 4'b1000; d1[3] = 8'h30;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("stream_ready", 32'(rdy1), 32'b1000);
      if (k > 0) begin
        chk("stream_valid", 32'(vo1), 1);
        chk("stream_data", 32'(do1), 32'(8'h30 + 8'(k - 1)));
      end
      step();
      d1[3] = 8'h30 + 8'(k + 1);
    end
    v1 = 4'b0000; #1;
    chk("stream_last_valid", 32'(vo1), 1);
    chk("stream_last_data", 32'(do1), 32'h39);
    step(); #1;
    chk("stream_drained", 32'(vo1), 0);

    // Mid-stream reset discards the buffered beat and clears the pointer
    v1 = 4'b0010; d1[1] = 8'h55; ro1 = 1'b0; #1;
    chk("mid_accept", 32'(rdy1), 32'b0010);
    step();
    v1 = 4'b0000; #1;
    chk("mid_buffered_valid", 32'(vo1), 1);
    chk("mid_buffered_data", 32'(do1), 32'h55);
    rst1 = 1'b1; step(); #1;
    chk("mid_rst_valid", 32'(vo1), 0);
    chk("mid_rst_sel", 32'(so1), 0);
    rst1 = 1'b0; ro1 = 1'b1; v1 = 4'b0101; d1[0] = 8'h50; d1[2] = 8'h52; #1;
    chk("mid_post_valid", 32'(vo1), 0);
    chk("mid_post_ready", 32'(rdy1), 0);
    step(); #1;
    chk("mid_ptr_zero", 32'(rdy1), 32'b0001);
    chk("mid_no_ghost", 32'(vo1), 0);
    step(); #1;
    chk("mid_new_beat", 32'(do1), 32'h50);
    v1 = 4'b0000;

    // Randomized run of both instances against the reference model
    rst0 = 1'b1; rst1 = 1'b1; v0 = '0; v1 = '0;
    step(); step(); rst0 = 1'b0; rst1 = 1'b0; step();
    p0 = 0; p1 = 0; lk0 = -1; ov1 = 1'b0; od1 = '0; os1 = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int j = 0; j < 4; j++) begin
        if (!v0[j] && $urandom_range(0, 1) == 1) begin v0[j] = 1'b1; d0[j] = 8'($urandom); end
        if (!v1[j] && $urandom_range(0, 1) == 1) begin v1[j] = 1'b1; d1[j] = 8'($urandom); end
      end
      ro0 = ($urandom_range(0, 9) < 7);
      ro1 = ($urandom_range(0, 9) < 7);
      #1;
      w0 = (lk0 >= 0) ? lk0 : pick(v0, p0);
      chk("rnd0_ready_in", 32'(rdy0), 32'(ro0 ? oh(w0) : 4'b0000));
      chk("rnd0_valid_out", 32'(vo0), 32'(|v0));
      chk("rnd0_data_out", 32'(do0), 32'((w0 >= 0) ? d0[w0] : 8'h00));
      chk("rnd0_sel_out", 32'(so0), 32'(oh(w0)));
      w1 = pick(v1, p1);
      can1 = !ov1 || ro1;
      chk("rnd1_ready_in", 32'(rdy1), 32'(can1 ? oh(w1) : 4'b0000));
      chk("rnd1_valid_out", 32'(vo1), 32'(ov1));
      chk("rnd1_sel_out", 32'(so1), 32'(ov1 ? oh(os1) : 4'b0000));
      if (ov1) chk("rnd1_data_out", 32'(do1), 32'(od1));
      step();
      if (w0 >= 0) begin
        if (ro0) begin p0 = (w0 + 1) % 4; lk0 = -1; v0[w0] = 1'b0; end
        else lk0 = w0;
      end
      if (w1 >= 0 && can1) begin
        ov1 = 1'b1; od1 = d1[w1]; os1 = w1; p1 = (w1 + 1) % 4; v1[w1] = 1'b0;
      end else if (ro1) begin
        ov1 = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
